// File: rtl/comp_share_arbiter_if.sv
// Request/result bundle between the compare clients and comp_share_arbiter.
// Requester k owns bit k of the one-hot vectors and 32-bit slice k of a_i/b_i.
interface comp_share_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_i;
  logic [NREQ*32-1:0] a_i;
  logic [NREQ*32-1:0] b_i;
  logic [NREQ-1:0]    gnt_o;
  logic [NREQ-1:0]    done_o;
  logic [IDW-1:0]     id_o;
  logic               bg_o;
  logic               eq_o;
  logic               sl_o;
  logic               busy_o;

  modport master (
    output req_i, a_i, b_i,
    input  gnt_o, done_o, id_o, bg_o, eq_o, sl_o, busy_o
  );

  modport slave (
    input  req_i, a_i, b_i,
    output gnt_o, done_o, id_o, bg_o, eq_o, sl_o, busy_o
  );
endinterface

// File: rtl/comp_share_arbiter.sv
// Round-robin scheduler sharing one unsigned 32-bit cascadable comparator
// between NREQ requesters: arbitrate, latch operands, compare, return result.
module comparator_32b_io (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        AbgB_i,
  input  logic        AslB_i,
  input  logic        AeqB_i,
  output logic        AbgB_o,
  output logic        AslB_o,
  output logic        AeqB_o
);
  always_comb begin
    if (a_i > b_i) begin
      {AbgB_o, AeqB_o, AslB_o} = 3'b100;
    end else if (a_i < b_i) begin
      {AbgB_o, AeqB_o, AslB_o} = 3'b001;
    end else begin
      {AbgB_o, AeqB_o, AslB_o} = {AbgB_i, AeqB_i, AslB_i};
    end
  end
endmodule

module comp_share_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  comp_share_arbiter_if.slave   bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_COMPARE,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic            bg_q, bg_d;
  logic            eq_q, eq_d;
  logic            sl_q, sl_d;

  logic [IDW-1:0]  idx;
  logic [IDW-1:0]  win;
  logic            win_vld;
  logic            cmp_bg, cmp_eq, cmp_sl;
  logic [NREQ-1:0] id_onehot;

  // Scan upward from ptr, wrapping at NREQ-1; the first requester found wins.
  always_comb begin
    idx     = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(ptr_q) + i) % NREQ);
      if (!win_vld && bus.req_i[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  // Only the operand registers reach the comparator, so clients may change
  // their operands as soon as the grant has been taken.
  comparator_32b_io u_cmp (
    .a_i    (a_q),
    .b_i    (b_q),
    .AbgB_i (1'b0),
    .AslB_i (1'b0),
    .AeqB_i (1'b1),
    .AbgB_o (cmp_bg),
    .AslB_o (cmp_sl),
    .AeqB_o (cmp_eq)
  );

  always_comb begin
    // NOTE: every next-state value starts as a hold of its flop, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    bg_d    = bg_q;
    eq_d    = eq_q;
    sl_d    = sl_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          id_d    = win;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        a_d     = bus.a_i[{id_q, 5'd0} +: 32];
        b_d     = bus.b_i[{id_q, 5'd0} +: 32];
        ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
        state_d = S_COMPARE;
      end
      S_COMPARE: begin
        bg_d    = cmp_bg;
        eq_d    = cmp_eq;
        sl_d    = cmp_sl;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the operand and result registers are plain flops, not a memory, so
  // they take the reset like everything else and never start as X.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bg_q    <= 1'b0;
      eq_q    <= 1'b0;
      sl_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bg_q    <= bg_d;
      eq_q    <= eq_d;
      sl_q    <= sl_d;
    end
  end

  assign id_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << id_q;
  assign bus.gnt_o   = (state_q == S_GRANT) ? id_onehot : '0;
  assign bus.done_o  = (state_q == S_DONE)  ? id_onehot : '0;
  assign bus.id_o    = id_q;
  assign bus.bg_o    = bg_q;
  assign bus.eq_o    = eq_q;
  assign bus.sl_o    = sl_q;
  assign bus.busy_o  = (state_q != S_IDLE);
endmodule
